// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// owner ids, default bus widths and the hold-counter width helper.
// Imported by dmem_arbiter and dmem_arbiter_hold_counter.
package dmem_arbiter_pkg;

  localparam int DEF_AWIDTH = 11;
  localparam int DEF_DWIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_DBG = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_t;

  // Bits needed to count 0..max_hold-1, never less than one bit.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold <= 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/dmem_arbiter_hold_counter.sv
// Hold counter: clear/increment/saturate at MAX_HOLD-1, flags limit reached.
// Latency: count updates one cycle after inc; at_limit is combinational from the count.
// Backpressure: none; clr has priority over inc, saturates instead of wrapping.
// Ports: clk, rst (sync, active-high), clr, inc, at_limit (count == MAX_HOLD-1).
module dmem_arbiter_hold_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = hold_cnt_width(MAX_HOLD);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between CPU and debug/loader ports; round-robin ties, hold limit, debug lock.
// Latency: req in IDLE -> gnt/transfer next cycle -> rvalid+rdata the cycle after; 1 transfer/cycle when owning.
// Backpressure: requesters hold req/addr/we/wdata stable until granted; grant is a registered owner state.
// Ports: cpu_*/dbg_* requester sides, dbg_lock, rdata (registered), mem_* memory pins.
// Optional: define DMEM_ARB_STATS_EN for saturating cpu_xfer_cnt/dbg_xfer_cnt/conflict_cnt outputs.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int MAX_HOLD = 4
`ifdef DMEM_ARB_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [AWIDTH-1:0] dbg_addr,
  input  logic [DWIDTH-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  input  logic              dbg_lock,
  output logic [DWIDTH-1:0] rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  , output logic [STAT_WIDTH-1:0] cpu_xfer_cnt
  , output logic [STAT_WIDTH-1:0] dbg_xfer_cnt
  , output logic [STAT_WIDTH-1:0] conflict_cnt
`endif
);

  arb_state_t state, state_nxt;
  owner_t     last_owner;
  logic       cpu_xfer, dbg_xfer;
  logic       hold_at_limit, hold_clr, hold_inc;

  assign cpu_gnt = (state == ST_OWN_CPU);
  assign dbg_gnt = (state == ST_OWN_DBG);

  // A transfer in the reset cycle is suppressed so no strobe reaches memory.
  assign cpu_xfer = cpu_gnt && cpu_req && !rst;
  assign dbg_xfer = dbg_gnt && dbg_req && !rst;

  // Hold only counts while the other side is actually waiting.
  assign hold_inc = (cpu_xfer && dbg_req) || (dbg_xfer && cpu_req);
  assign hold_clr = (state == ST_IDLE) || (state_nxt != state);

  dmem_arbiter_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clr      (hold_clr),
    .inc      (hold_inc),
    .at_limit (hold_at_limit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cpu_req && dbg_req) begin
          state_nxt = (last_owner == OWNER_DBG) ? ST_OWN_CPU : ST_OWN_DBG;
        end else if (cpu_req) begin
          state_nxt = ST_OWN_CPU;
        end else if (dbg_req) begin
          state_nxt = ST_OWN_DBG;
        end
      end
      ST_OWN_CPU: begin
        if (dbg_req && (!cpu_req || hold_at_limit)) begin
          state_nxt = ST_OWN_DBG;
        end else if (!cpu_req && !dbg_req) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_OWN_DBG: begin
        // Lock pins ownership even with dbg_req low; the CPU just waits.
        if (!dbg_lock) begin
          if (cpu_req && (!dbg_req || hold_at_limit)) begin
            state_nxt = ST_OWN_CPU;
          end else if (!dbg_req && !cpu_req) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_xfer) begin
      mem_wr    = cpu_we;
      mem_rd    = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_xfer) begin
      mem_wr    = dbg_we;
      mem_rd    = !dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_owner <= OWNER_DBG;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      rdata      <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_OWN_CPU) begin
        last_owner <= OWNER_CPU;
      end else if (state_nxt == ST_OWN_DBG) begin
        last_owner <= OWNER_DBG;
      end
      cpu_rvalid <= cpu_xfer && !cpu_we;
      dbg_rvalid <= dbg_xfer && !dbg_we;
      if ((cpu_xfer && !cpu_we) || (dbg_xfer && !dbg_we)) begin
        rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_xfer_cnt <= '0;
      dbg_xfer_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (cpu_xfer && (cpu_xfer_cnt != '1)) begin
        cpu_xfer_cnt <= cpu_xfer_cnt + 1'b1;
      end
      if (dbg_xfer && (dbg_xfer_cnt != '1)) begin
        dbg_xfer_cnt <= dbg_xfer_cnt + 1'b1;
      end
      if (cpu_req && dbg_req && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory attached.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   cpu_xfer_cnt, dbg_xfer_cnt, conflict_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  dmem_arbiter u_dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_lock   (dbg_lock),
    .rdata      (rdata),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .cpu_xfer_cnt (cpu_xfer_cnt)
    , .dbg_xfer_cnt (dbg_xfer_cnt)
    , .conflict_cnt (conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Memory writes may only happen when debug owns and requests.
  always @(negedge clk) begin
    if (mon_en) chk("wr_qual", 32'(mem_wr && !(dbg_gnt && dbg_req)), 32'd0);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    mem[5] = 16'h1234;

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_lock = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    mid();
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    next_cycle();

    // 1: single CPU read from IDLE
    cpu_req = 1'b1; cpu_addr = 11'h005;
    mid();
    chk("s1_c0_cpu_gnt", 32'(cpu_gnt), 32'd0);
    next_cycle();
    mid();
    chk("s1_c1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("s1_c1_mem_rd", 32'(mem_rd), 32'd1);
    chk("s1_c1_mem_addr", 32'(mem_addr), 32'h005);
    next_cycle();
    cpu_req = 1'b0;
    mid();
    chk("s1_c2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("s1_c2_rdata", 32'(rdata), 32'h1234);
    chk("s1_c2_mem_rd", 32'(mem_rd), 32'd0);
    next_cycle();
    mid();
    chk("s1_c3_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("s1_c3_cpu_gnt", 32'(cpu_gnt), 32'd0);
    next_cycle();

    // 2: tie from IDLE after reset, hold limit alternation
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 11'h001;
    dbg_req = 1'b1; dbg_addr = 11'h002;
    for (int c = 0; c < 12; c++) begin
      logic exp_cpu, exp_dbg;
      exp_cpu = (c >= 1 && c <= 4) || (c >= 9);
      exp_dbg = (c >= 5 && c <= 8);
      mid();
      chk($sformatf("s2_c%0d_cpu_gnt", c), 32'(cpu_gnt), 32'(exp_cpu));
      chk($sformatf("s2_c%0d_dbg_gnt", c), 32'(dbg_gnt), 32'(exp_dbg));
      if (exp_cpu) chk($sformatf("s2_c%0d_addr", c), 32'(mem_addr), 32'h001);
      if (exp_dbg) chk($sformatf("s2_c%0d_addr", c), 32'(mem_addr), 32'h002);
      if (c == 5) begin
        chk("s2_c5_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("s2_c5_rdata", 32'(rdata), 32'h1111);
      end
      if (c == 9) begin
        chk("s2_c9_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("s2_c9_rdata", 32'(rdata), 32'h2222);
      end
      next_cycle();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    mid();
`ifdef DMEM_ARB_STATS_EN
    chk("s6_cpu_xfer_cnt", 32'(cpu_xfer_cnt), 32'd7);
    chk("s6_dbg_xfer_cnt", 32'(dbg_xfer_cnt), 32'd4);
    chk("s6_conflict_cnt", 32'(conflict_cnt), 32'd12);
`endif
    chk("s2_c12_mem_rd", 32'(mem_rd), 32'd0);
    next_cycle();

    // 3: debug write then CPU read-back
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11'h00A; dbg_wdata = 16'hBEEF;
    mid();
    chk("s3_idle_dbg_gnt", 32'(dbg_gnt), 32'd0);
    next_cycle();
    mid();
    chk("s3_dbg_gnt", 32'(dbg_gnt), 32'd1);
    chk("s3_mem_wr", 32'(mem_wr), 32'd1);
    chk("s3_mem_addr", 32'(mem_addr), 32'h00A);
    chk("s3_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    next_cycle();
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_req = 1'b1; cpu_addr = 11'h00A;
    mid();
    chk("s3_noreq_mem_wr", 32'(mem_wr), 32'd0);
    next_cycle();
    mid();
    chk("s3_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("s3_cpu_mem_rd", 32'(mem_rd), 32'd1);
    next_cycle();
    cpu_req = 1'b0;
    mid();
    chk("s3_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("s3_rdata", 32'(rdata), 32'hBEEF);
    next_cycle();

    // 4: debug lock holds ownership past MAX_HOLD, even with dbg_req low
    dbg_req = 1'b1; dbg_addr = 11'h002; dbg_lock = 1'b1;
    mid();
    chk("s4_idle_dbg_gnt", 32'(dbg_gnt), 32'd0);
    next_cycle();
    for (int k = 0; k <= 10; k++) begin
      cpu_req = 1'b1; cpu_addr = 11'h005;
      dbg_req = !(k == 3 || k == 4);
      dbg_lock = (k < 10);
      mid();
      chk($sformatf("s4_k%0d_dbg_gnt", k), 32'(dbg_gnt), 32'd1);
      chk($sformatf("s4_k%0d_cpu_gnt", k), 32'(cpu_gnt), 32'd0);
      chk($sformatf("s4_k%0d_mem_rd", k), 32'(mem_rd), 32'(dbg_req));
      if (k == 1) chk("s4_k1_rdata", 32'(rdata), 32'h2222);
      next_cycle();
    end
    dbg_req = 1'b0; dbg_lock = 1'b0;
    mid();
    chk("s4_unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("s4_unlock_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("s4_unlock_addr", 32'(mem_addr), 32'h005);
    next_cycle();

    // 5: reset during a granted CPU read
    rst = 1'b1;
    mid();
    chk("s5_rstcyc_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("s5_rstcyc_mem_rd", 32'(mem_rd), 32'd0);
    next_cycle();
    rst = 1'b0;
    mid();
    chk("s5_post_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("s5_post_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("s5_post_rdata", 32'(rdata), 32'd0);
    chk("s5_post_mem_rd", 32'(mem_rd), 32'd0);
    next_cycle();
    mid();
    chk("s5_regrant_cpu_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_req = 1'b0;
    mon_en = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
